// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit sampling, optional parity and a
// first-word-fall-through receive FIFO. Define UART_RX_BREAK_DET_EN to detect and swallow line breaks.
module uart_rx_fifo #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        uart_rx_in,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_frame_err,
   output logic                        rx_parity_err,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overrun_err,
   input  logic                        err_clr,
   output logic                        break_det
);
   localparam int DIV = (CLK_FREQ_HZ + 8*BAUD_RATE) / (16*BAUD_RATE);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int EW  = DATA_BITS + 2;
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_sync1, r_sync2, r_sync3;
   logic [15:0]          r_div;
   logic [3:0]           r_smp, r_bit;
   logic                 r_s7, r_s8, r_par_bit, r_break;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_fall, w_tick, w_maj, w_mid, w_end;
   logic                 w_push, w_break, w_par_err;

   // Synchroniser flops idle high so reset can never look like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= uart_rx_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_fall = r_sync3 & ~r_sync2;
   assign w_tick = (r_div == 16'(DIV - 1));
   assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   assign w_mid  = w_tick && (r_smp == 4'd9);
   assign w_end  = w_tick && (r_smp == 4'd15);

   always_comb begin
      w_par_err = 1'b0;
      if (PARITY == 1)      w_par_err = ~(^r_shift ^ r_par_bit);
      else if (PARITY == 2) w_par_err = ^r_shift ^ r_par_bit;
   end

`ifdef UART_RX_BREAK_DET_EN
   logic w_is_break;
   assign w_is_break = (r_shift == '0) && !r_par_bit && !w_maj;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_break     = 1'b0;
      case (r_state)
         S_IDLE:   if (w_fall) w_state_nxt = S_START;
         S_START: begin
            if (w_mid && w_maj) w_state_nxt = S_IDLE;
            else if (w_end)     w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_end && (r_bit == 4'(DATA_BITS - 1)))
               w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: if (w_end) w_state_nxt = S_STOP;
         S_STOP: begin
            // Leave at mid-stop so a following start edge is never missed
            if (w_mid) begin
`ifdef UART_RX_BREAK_DET_EN
               if (w_is_break) begin
                  w_break     = 1'b1;
                  w_state_nxt = S_BRK_WAIT;
               end else begin
                  w_push      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
`else
               w_push      = 1'b1;
               w_state_nxt = S_IDLE;
`endif
            end
         end
         S_BRK_WAIT: if (w_tick && r_sync2 && (r_smp == 4'd15)) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div     <= '0;
         r_smp     <= '0;
         r_bit     <= '0;
         r_s7      <= 1'b1;
         r_s8      <= 1'b1;
         r_par_bit <= 1'b0;
         r_shift   <= '0;
         r_break   <= 1'b0;
      end else begin
         r_break <= w_break;
         if ((r_state == S_IDLE) && w_fall) begin
            r_div <= '0;
            r_smp <= '0;
         end else if (w_tick) begin
            r_div <= '0;
            // In BRK_WAIT the sample counter measures consecutive high ticks
            if (w_break || ((r_state == S_BRK_WAIT) && !r_sync2)) r_smp <= '0;
            else                                                   r_smp <= r_smp + 4'd1;
         end else begin
            r_div <= r_div + 16'd1;
         end
         if (w_tick && (r_smp == 4'd7)) r_s7 <= r_sync2;
         if (w_tick && (r_smp == 4'd8)) r_s8 <= r_sync2;
         if (r_state == S_START)                 r_bit <= '0;
         else if ((r_state == S_DATA) && w_end)  r_bit <= r_bit + 4'd1;
         if ((r_state == S_DATA) && w_mid)   r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
         if ((r_state == S_PARITY) && w_mid) r_par_bit <= w_maj;
      end
   end

   // Receive FIFO: entry = {parity_err, frame_err, data}
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overrun;
   logic          w_full, w_pop, w_wr_en;
   logic [EW-1:0] w_head;

   assign rx_valid = (r_count != '0);
   assign w_full   = (r_count == DEPTH_C);
   assign w_pop    = rx_valid && rx_ready;
   assign w_wr_en  = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= {w_par_err, ~w_maj, r_shift};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
         else if (err_clr)               r_overrun <= 1'b0;
      end
   end

   assign w_head        = r_mem[r_rd_ptr];
   assign rx_data       = rx_valid ? w_head[DATA_BITS-1:0] : '0;
   assign rx_frame_err  = rx_valid && w_head[DATA_BITS];
   assign rx_parity_err = rx_valid && w_head[DATA_BITS+1];
   assign fifo_count    = r_count;
   assign overrun_err   = r_overrun;
   assign break_det     = r_break;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an even-parity instance, driven with directed and
// random frames; a queue model of received characters is checked on every FIFO pop.
module tb_uart_rx_fifo;
   localparam int CLK_HZ = 7000000;
   localparam int BAUD   = 100000;
   localparam int DIV_M  = (CLK_HZ + 8*BAUD) / (16*BAUD);
   localparam int BIT    = 16 * DIV_M;
   localparam int DEPTH  = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line_a, line_b;
   logic [7:0] data_a, data_b;
   logic       ferr_a, perr_a, valid_a, ready_a, ovr_a, clr_a, brk_a;
   logic       ferr_b, perr_b, valid_b, ready_b, ovr_b, clr_b, brk_b;
   logic [4:0] cnt_a, cnt_b;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [9:0] exp_qa[$];
   logic [9:0] exp_qb[$];
   int         brk_exp_a, brk_seen_a, brk_exp_b, brk_seen_b;
   bit         m_ovr_a;
   bit         rand_ready, ready_force;
   int         rise_cyc_a, t0;
   logic       prev_valid_a;

   uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .FIFO_DEPTH(DEPTH)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .uart_rx_in(line_a), .rx_data(data_a),
      .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_valid(valid_a), .rx_ready(ready_a),
      .fifo_count(cnt_a), .overrun_err(ovr_a), .err_clr(clr_a), .break_det(brk_a));

   uart_rx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                  .FIFO_DEPTH(DEPTH)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .uart_rx_in(line_b), .rx_data(data_b),
      .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_valid(valid_b), .rx_ready(ready_b),
      .fifo_count(cnt_b), .overrun_err(ovr_b), .err_clr(clr_b), .break_det(brk_b));

   // clock / reset-independent infrastructure
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      ready_a = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) line_b = v;
      else     line_a = v;
   endtask

   task automatic drive_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input bit par, input bit stop);
      drive(sel, 1'b0);
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         wait_clk(BIT);
      end
      if (has_par) begin
         drive(sel, par);
         wait_clk(BIT);
      end
      drive(sel, stop);
      wait_clk(BIT);
      drive(sel, 1'b1);
   endtask

   // Reference model: what a correct receiver must deliver for one frame
   function automatic void expect_frame(input bit sel, input logic [7:0] d, input bit has_par,
                                        input bit par, input bit stop);
      logic perr;
      perr = has_par ? ((^d) ^ par) : 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      if ((d == 8'h00) && !stop && (!has_par || !par)) begin
         if (sel) brk_exp_b++;
         else     brk_exp_a++;
         return;
      end
`endif
      if (sel)
         exp_qb.push_back({perr, ~stop, d});
      else if (!rand_ready && !ready_force && (exp_qa.size() >= DEPTH))
         m_ovr_a = 1'b1;
      else
         exp_qa.push_back({perr, ~stop, d});
   endfunction

   // Scoreboard: every pop must match the oldest expected character
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid_a && !prev_valid_a) rise_cyc_a = cyc;
         prev_valid_a = valid_a;
         if (brk_a) brk_seen_a++;
         if (brk_b) brk_seen_b++;
         if (valid_a && ready_a) begin
            if (exp_qa.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_pop: got entry 0x%0h, expected none", {perr_a, ferr_a, data_a});
            end else check("a_pop", {perr_a, ferr_a, data_a}, exp_qa.pop_front());
         end
         if (valid_b && ready_b) begin
            if (exp_qb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_pop: got entry 0x%0h, expected none", {perr_b, ferr_b, data_b});
            end else check("b_pop", {perr_b, ferr_b, data_b}, exp_qb.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] d;
      bit         stop, par;
      rst_n = 1'b0; line_a = 1'b1; line_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0; ready_b = 1'b1;
      rand_ready = 1'b0; ready_force = 1'b1; m_ovr_a = 1'b0; prev_valid_a = 1'b0;
      brk_exp_a = 0; brk_seen_a = 0; brk_exp_b = 0; brk_seen_b = 0; rise_cyc_a = 0;
      wait_clk(3);
      check("rst_valid", valid_a, 0);
      check("rst_count", cnt_a, 0);
      check("rst_data", data_a, 0);
      check("rst_flags", {ovr_a, ferr_a, perr_a, brk_a}, 0);
      check("rst_b_outputs", {valid_b, cnt_b, ovr_b, brk_b}, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // 8N1 character, consumer always ready
      t0 = cyc;
      exp_qa.push_back({2'b00, 8'hA5});
      drive_frame(0, 8'hA5, 0, 0, 1);
      wait_clk(8);
      check("t1_valid_timing", (rise_cyc_a - t0 >= 9*BIT + BIT/2) && (rise_cyc_a - t0 <= 10*BIT), 1);
      check("t1_count", cnt_a, 0);
      check("t1_received", exp_qa.size(), 0);

      // Even parity: correct then wrong parity bit
      exp_qb.push_back({2'b00, 8'h3C});
      drive_frame(1, 8'h3C, 1, 0, 1);
      exp_qb.push_back({2'b10, 8'h3C});
      drive_frame(1, 8'h3C, 1, 1, 1);
      wait_clk(8);
      check("t2_received", exp_qb.size(), 0);
      check("t2_count", cnt_b, 0);

      // Frame error, then a short glitch that must be rejected as a false start
      exp_qa.push_back({2'b01, 8'h55});
      drive_frame(0, 8'h55, 0, 0, 0);
      wait_clk(8);
      check("t3_frame_err_received", exp_qa.size(), 0);
      line_a = 1'b0;
      wait_clk(20);
      line_a = 1'b1;
      wait_clk(11*BIT);
      check("t3_glitch_valid", valid_a, 0);
      check("t3_glitch_count", cnt_a, 0);
      exp_qa.push_back({2'b00, 8'hC3});
      drive_frame(0, 8'hC3, 0, 0, 1);
      wait_clk(8);
      check("t3_after_glitch", exp_qa.size(), 0);

      // Fill past capacity with the consumer stalled
      ready_force = 1'b0;
      wait_clk(1);
      for (int i = 0; i < 17; i++) begin
         expect_frame(0, 8'(i), 0, 0, 1);
         drive_frame(0, 8'(i), 0, 0, 1);
         wait_clk(4);
         check("t4_fill_count", cnt_a, exp_qa.size());
      end
      check("t4_full_count", cnt_a, 16);
      check("t4_overrun", ovr_a, m_ovr_a);
      ready_force = 1'b1;
      wait_clk(40);
      check("t4_drained", exp_qa.size(), 0);
      check("t4_count_empty", cnt_a, 0);
      check("t4_overrun_sticky", ovr_a, 1);
      clr_a = 1'b1;
      wait_clk(1);
      clr_a = 1'b0;
      m_ovr_a = 1'b0;
      wait_clk(1);
      check("t4_overrun_cleared", ovr_a, m_ovr_a);

      // Reset in the middle of 0x81
      ready_force = 1'b0;
      wait_clk(1);
      line_a = 1'b0;
      wait_clk(BIT);
      d = 8'h81;
      for (int i = 0; i < 4; i++) begin
         line_a = d[i];
         wait_clk(BIT);
      end
      rst_n = 1'b0;
      line_a = 1'b1;
      wait_clk(4);
      check("t5_in_reset_count", cnt_a, 0);
      rst_n = 1'b1;
      wait_clk(4);
      exp_qa.push_back({2'b00, 8'h7E});
      drive_frame(0, 8'h7E, 0, 0, 1);
      wait_clk(4);
      check("t5_count", cnt_a, 1);
      check("t5_head", data_a, 8'h7E);
      ready_force = 1'b1;
      wait_clk(4);
      check("t5_received", exp_qa.size(), 0);

      // Line break: 12 bit times low
`ifdef UART_RX_BREAK_DET_EN
      brk_exp_a++;
`else
      exp_qa.push_back({2'b01, 8'h00});
`endif
      line_a = 1'b0;
      wait_clk(12*BIT);
      line_a = 1'b1;
      wait_clk(2*BIT);
`ifdef UART_RX_BREAK_DET_EN
      check("t6_break_pulses", brk_seen_a, 1);
`else
      check("t6_break_pulses", brk_seen_a, 0);
`endif
      check("t6_received", exp_qa.size(), 0);
      check("t6_count", cnt_a, 0);

      // Random frames, random consumer back-pressure
      rand_ready = 1'b1;
      repeat (20) begin
         d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         expect_frame(0, d, 0, 0, stop);
         drive_frame(0, d, 0, 0, stop);
         wait_clk($urandom_range(4, 40));
         if ((d == 8'h00) && !stop) wait_clk(2*BIT);
      end
      rand_ready = 1'b0;
      wait_clk(40);
      check("rand_a_received", exp_qa.size(), 0);
      check("rand_a_count", cnt_a, 0);
      check("rand_a_breaks", brk_seen_a, brk_exp_a);

      repeat (12) begin
         d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         par = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 3) != 0);
         expect_frame(1, d, 1, par, stop);
         drive_frame(1, d, 1, par, stop);
         wait_clk($urandom_range(4, 40));
         if ((d == 8'h00) && !stop && !par) wait_clk(2*BIT);
      end
      wait_clk(20);
      check("rand_b_received", exp_qb.size(), 0);
      check("rand_b_breaks", brk_seen_b, brk_exp_b);
      check("final_overrun_a", ovr_a, m_ovr_a);
      check("final_overrun_b", ovr_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It uses 16x oversampling with majority-vote sampling, and the data width, parity mode and baud rate are configurable. Frame and parity errors are reported per character. Received characters are buffered in a first-word-fall-through FIFO with a valid/ready output, so consumers such as the LED controller no longer need to catch a single-cycle strobe.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency
BAUD_RATE, 115200, line rate
DATA_BITS, 8, character width, legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
FIFO_DEPTH, 16, receive FIFO entries, power of two, minimum 2

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
uart_rx_in  in  1  serial line, idles high, asynchronous to clk
rx_data  out  DATA_BITS  head-of-FIFO character
rx_frame_err  out  1  stop bit of the head character sampled low
rx_parity_err  out  1  parity mismatch on the head character; always 0 when PARITY=0
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head entry
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun_err  out  1  sticky flag: a character was dropped because the FIFO was full
err_clr  in  1  single-cycle pulse that clears overrun_err
break_det  out  1  single-cycle pulse on a line break (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 and FIFO empty. The two synchroniser flops reset to 1 (idle line), so reset never produces a false start. The FSM resets to IDLE and the tick divider to 0.
- Reset asserted mid-frame: the partial character is discarded and nothing is pushed.
- Input synchronisation: uart_rx_in passes through a 2-flop synchroniser before any use.
- Tick divider:
  - DIV = (CLK_FREQ_HZ + 8*BAUD_RATE) / (16*BAUD_RATE), i.e. rounded; at the defaults DIV = 27.
  - tick pulses for one cycle every DIV clocks.
  - The divider restarts at 0 on the start edge so sampling is phase-aligned to the frame.
- Sampling: a sample counter runs 0..15 per bit on tick. Each bit value is the majority of samples 7, 8 and 9.
- FSM states and transitions:
  - IDLE: a synchronised falling edge moves to START.
  - START: if the start-bit majority is 1, the start is false; return to IDLE with no push. Otherwise go to DATA.
  - DATA: receive DATA_BITS bits, LSB first, into a shift register. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: check received parity against the data. parity_err = 1 on mismatch (odd mode: total ones in data+parity must be odd; even mode: even).
  - STOP: at sample 9, push {parity_err, frame_err, data}; frame_err = stop majority is 0. Return to IDLE in that same cycle, so a new start edge is accepted during the second half of the stop bit.
- FIFO behaviour:
  - First-word-fall-through: rx_data, rx_frame_err and rx_parity_err always reflect the head entry while rx_valid = 1.
  - Pop occurs when rx_valid && rx_ready.
  - Latency: rx_valid and the updated fifo_count are visible the cycle after the push cycle.
- FIFO boundary cases:
  - Push when full with no pop in the same cycle: the character is dropped, overrun_err is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the push is accepted, no overrun, count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Error clear: if err_clr and a new overrun occur in the same cycle, overrun_err remains 1 (set wins).

Optional Feature:
Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - A frame where all data bits are 0, the parity bit (if present) is 0 and the stop bit is 0 is a break. It raises break_det for one cycle and is not pushed to the FIFO.
  - The FSM then waits in BREAK_WAIT until the synchronised line has been high for one full bit time (16 ticks), then returns to IDLE.
- Not defined:
  - break_det is tied to 0.
  - A break frame is pushed as data 0 with rx_frame_err = 1.
  - The FSM returns to IDLE immediately, and re-arms on the next falling edge.

Test Plan:
1. Defaults (8N1 at 115200, bit period 432 clocks), send 0xA5 with rx_ready = 1. Required: rx_valid rises after the stop-bit sample, rx_data = 0xA5, both error flags 0, fifo_count returns to 0 after the pop.
2. PARITY = 2, send 0x3C with a correct parity bit of 0, then 0x3C with parity bit 1. Required: first entry has rx_parity_err = 0, second has rx_parity_err = 1, data 0x3C in both.
3. Send 0x55 with the stop bit forced low. Required: entry shows rx_data = 0x55 and rx_frame_err = 1. Separately, apply a 200-clock low glitch on the line. Required: no push and the FSM is back in IDLE.
4. rx_ready = 0, send 17 characters 0x00..0x10. Required: fifo_count = 16 and overrun_err = 1. Draining yields 0x00..0x0F in order. One err_clr pulse then clears overrun_err.
5. Assert rst_n low halfway through the DATA bits of 0x81, release it, then send 0x7E. Required: only 0x7E is received and fifo_count = 1.
6. Hold the line low for 12 bit times, then high. With UART_RX_BREAK_DET_EN defined: one break_det pulse and fifo_count = 0. Without it: one entry with data 0x00, rx_frame_err = 1, break_det never asserts.
